// File: rtl/attack_envelope_sequencer.sv
// Attack-phase sequencer for the VM2413 envelope path: per-slot phase accumulation,
// shaping-table addressing, and conversion of table data into a slot-tagged attenuation.
//
// state  | meaning
// IDLE   | key released; phase 0, output silent
// ATTACK | phase accumulating toward full scale; output follows the shaping table
// DONE   | attack complete; phase pinned at full scale, output at full level
module attack_envelope_sequencer #(
  parameter int NUM_SLOTS = 18,
  parameter int PHASE_W   = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clkena,
  input  logic [4:0]         slot,
  input  logic               key_on,
  input  logic [5:0]         rate,
  output logic [PHASE_W-1:0] tbl_addr,
  input  logic [12:0]        tbl_data,
  output logic [12:0]        env_out,
  output logic [4:0]         env_slot,
  output logic               env_valid,
  output logic               attack_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ATTACK = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int                 PIPE_DEPTH = 3;
  localparam logic [PHASE_W-1:0] PHASE_MAX  = '1;
  localparam logic [12:0]        ENV_SILENT = 13'h1FC0;
  localparam logic [5:0]         RATE_FAST  = 6'd60;

  state_t               slot_state [NUM_SLOTS];
  logic [PHASE_W-1:0]   slot_phase [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_key;

  logic               slot_valid;
  logic [4:0]         slot_idx;
  state_t             cur_state;
  state_t             nxt_state;
  logic [PHASE_W-1:0] cur_phase;
  logic [PHASE_W-1:0] nxt_phase;
  logic [PHASE_W-1:0] addr_nxt;
  logic               cur_key;
  logic               complete;
  logic               rate_fast;
  logic [PHASE_W:0]   inc;
  logic [PHASE_W:0]   sum;

  // Metadata travelling alongside the table read, index 2 aligns with tbl_data.
  logic [4:0]  pipe_slot  [PIPE_DEPTH];
  logic        pipe_valid [PIPE_DEPTH];
  state_t      pipe_state [PIPE_DEPTH];
  logic        pipe_done  [PIPE_DEPTH];
  logic [12:0] env_nxt;

  assign slot_valid = (int'(slot) < NUM_SLOTS);
  assign slot_idx   = slot_valid ? slot : 5'd0;
  assign cur_state  = slot_state[slot_idx];
  assign cur_phase  = slot_phase[slot_idx];
  assign cur_key    = slot_key[slot_idx];
  assign rate_fast  = (rate >= RATE_FAST);

  // One extra bit on the sum so the clamp test sees overflow past full scale.
  assign inc = (PHASE_W+1)'({1'b1, rate[1:0]}) << rate[5:2];
  assign sum = {1'b0, cur_phase} + inc;

  // State register: per-slot storage and the table address.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_state[i] <= ST_IDLE;
        slot_phase[i] <= '0;
      end
      slot_key <= '0;
      tbl_addr <= '0;
    end else if (clkena && slot_valid) begin
      slot_state[slot_idx] <= nxt_state;
      slot_phase[slot_idx] <= nxt_phase;
      slot_key[slot_idx]   <= key_on;
      tbl_addr             <= addr_nxt;
    end
  end

  // Next-state logic for the slot being serviced.
  always_comb begin
    nxt_state = cur_state;
    nxt_phase = cur_phase;
    complete  = 1'b0;
    if (!key_on) begin
      nxt_state = ST_IDLE;
      nxt_phase = '0;
    end else if (!cur_key) begin
      if (rate_fast) begin
        nxt_state = ST_DONE;
        nxt_phase = PHASE_MAX;
        complete  = 1'b1;
      end else begin
        nxt_state = ST_ATTACK;
        nxt_phase = '0;
      end
    end else if (cur_state == ST_ATTACK) begin
      if (rate_fast || (rate != 6'd0 && sum >= {1'b0, PHASE_MAX})) begin
        nxt_state = ST_DONE;
        nxt_phase = PHASE_MAX;
        complete  = 1'b1;
      end else if (rate != 6'd0) begin
        nxt_phase = sum[PHASE_W-1:0];
      end
    end
  end

  // Output decode: table address for the new state, attenuation for the returning lane.
  always_comb begin
    addr_nxt = '0;
    case (nxt_state)
      ST_ATTACK: addr_nxt = nxt_phase;
      ST_DONE:   addr_nxt = PHASE_MAX;
      default:   addr_nxt = '0;
    endcase

    env_nxt = ENV_SILENT;
    case (pipe_state[PIPE_DEPTH-1])
      ST_ATTACK: env_nxt = ENV_SILENT - tbl_data;
      ST_DONE:   env_nxt = '0;
      default:   env_nxt = ENV_SILENT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_slot[i]  <= '0;
        pipe_valid[i] <= 1'b0;
        pipe_state[i] <= ST_IDLE;
        pipe_done[i]  <= 1'b0;
      end
      env_out     <= ENV_SILENT;
      env_slot    <= '0;
      env_valid   <= 1'b0;
      attack_done <= 1'b0;
    end else if (clkena) begin
      pipe_slot[0]  <= slot;
      pipe_valid[0] <= slot_valid;
      pipe_state[0] <= slot_valid ? nxt_state : ST_IDLE;
      pipe_done[0]  <= slot_valid & complete;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_slot[i]  <= pipe_slot[i-1];
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_state[i] <= pipe_state[i-1];
        pipe_done[i]  <= pipe_done[i-1];
      end
      env_out     <= env_nxt;
      env_slot    <= pipe_slot[PIPE_DEPTH-1];
      env_valid   <= pipe_valid[PIPE_DEPTH-1];
      attack_done <= pipe_done[PIPE_DEPTH-1] & pipe_valid[PIPE_DEPTH-1];
    end
  end

endmodule
